// File: rtl/level_controller_pkg.sv
// Shared game-progress definitions: state encoding and level/lives range defaults.
// Imported by the sequencer and by the display and round-generator stages so they agree on range.
// No logic; types and constants only.
package level_controller_pkg;

    // Sequencer states, one 3-bit code each.
    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_PLAY      = 3'd1,
        ST_PASS_HOLD = 3'd2,
        ST_FAIL_HOLD = 3'd3,
        ST_WIN       = 3'd4,
        ST_LOSE      = 3'd5
    } lc_state_t;

    // Highest level of a game (legal 1..15, fits the 4-bit level bus).
    localparam int DEF_MAX_LEVEL = 8;

    // Fails allowed per game (legal 1..3, fits the 2-bit lives bus).
    localparam int DEF_LIVES = 3;

    // Post-round hold: 1 s at 100 MHz.
    localparam int DEF_HOLD_CYCLES = 100_000_000;

endpackage

// File: rtl/level_controller_hold_timer.sv
// Post-round hold timer: active for exactly HOLD_CYCLES cycles after a load.
// Latency: active rises the cycle after load; done is high in the last active cycle.
// No backpressure; a load while active restarts the count from 0.
module hold_timer #(
    parameter int HOLD_CYCLES = 100_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    output logic active,
    output logic done
);

    // Counter only needs to reach HOLD_CYCLES-1; keep at least one bit for HOLD_CYCLES==1.
    localparam int CW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [CW-1:0] TERM = CW'(HOLD_CYCLES - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;
    logic          active_q;
    logic          active_d;

    // Next-state: restart on load, count while active, park at 0 when idle.
    always_comb begin
        cnt_d    = cnt_q;
        active_d = active_q;
        if (load) begin
            cnt_d    = '0;
            active_d = 1'b1;
        end else if (active_q) begin
            if (cnt_q == TERM) begin
                cnt_d    = '0;
                active_d = 1'b0;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    // Counter and activity registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q    <= '0;
            active_q <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            active_q <= active_d;
        end
    end

    assign active = active_q;
    assign done   = active_q && (cnt_q == TERM);

endmodule

// File: rtl/level_controller.sv
// Game-progress sequencer: level 1..MAX_LEVEL, lives, post-round hold, win/lose reporting.
// Latency: every output is registered and responds the cycle after the input pulse is sampled.
// No backpressure; pulses arriving while busy or outside PLAY are discarded.
module level_controller
    import level_controller_pkg::*;
#(
    parameter int MAX_LEVEL   = DEF_MAX_LEVEL,
    parameter int LIVES       = DEF_LIVES,
    parameter int HOLD_CYCLES = DEF_HOLD_CYCLES
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       round_pass,
    input  logic       round_fail,
    output logic [3:0] curr_level,
    output logic [1:0] lives_left,
    output logic       round_start,
    output logic       busy,
    output logic       game_won,
    output logic       game_over
);

    localparam logic [3:0] MAX_LEVEL_4 = 4'(MAX_LEVEL);
    localparam logic [1:0] LIVES_2     = 2'(LIVES);

    lc_state_t  state_q;
    logic [3:0] curr_level_q;
    logic [1:0] lives_left_q;
    logic       round_start_q;
    logic       game_won_q;
    logic       game_over_q;

    logic       hold_load;
    logic       hold_active;
    logic       hold_done;

    // A hold begins when PLAY sees a fail that leaves lives, or a pass below the top level.
    always_comb begin
        hold_load = 1'b0;
        if (state_q == ST_PLAY) begin
            if (round_fail) begin
                hold_load = (lives_left_q > 2'd1);
            end else if (round_pass) begin
                hold_load = (curr_level_q != MAX_LEVEL_4);
            end
        end
    end

    hold_timer #(
        .HOLD_CYCLES (HOLD_CYCLES)
    ) u_hold_timer (
        .clk    (clk),
        .rst    (rst),
        .load   (hold_load),
        .active (hold_active),
        .done   (hold_done)
    );

    // Sequencer FSM with level/lives and registered status outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            curr_level_q  <= 4'd0;
            lives_left_q  <= 2'd0;
            round_start_q <= 1'b0;
            game_won_q    <= 1'b0;
            game_over_q   <= 1'b0;
        end else begin
            round_start_q <= 1'b0;
            case (state_q)
                ST_IDLE, ST_WIN, ST_LOSE: begin
                    if (start) begin
                        state_q       <= ST_PLAY;
                        curr_level_q  <= 4'd1;
                        lives_left_q  <= LIVES_2;
                        round_start_q <= 1'b1;
                        game_won_q    <= 1'b0;
                        game_over_q   <= 1'b0;
                    end
                end
                ST_PLAY: begin
                    // Fail takes precedence over a simultaneous pass.
                    if (round_fail) begin
                        if (lives_left_q > 2'd1) begin
                            lives_left_q <= lives_left_q - 2'd1;
                            state_q      <= ST_FAIL_HOLD;
                        end else begin
                            lives_left_q <= 2'd0;
                            game_over_q  <= 1'b1;
                            state_q      <= ST_LOSE;
                        end
                    end else if (round_pass) begin
                        if (curr_level_q == MAX_LEVEL_4) begin
                            game_won_q <= 1'b1;
                            state_q    <= ST_WIN;
                        end else begin
                            state_q <= ST_PASS_HOLD;
                        end
                    end
                end
                ST_PASS_HOLD: begin
                    if (hold_done) begin
                        curr_level_q  <= curr_level_q + 4'd1;
                        round_start_q <= 1'b1;
                        state_q       <= ST_PLAY;
                    end
                end
                ST_FAIL_HOLD: begin
                    if (hold_done) begin
                        round_start_q <= 1'b1;
                        state_q       <= ST_PLAY;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign curr_level  = curr_level_q;
    assign lives_left  = lives_left_q;
    assign round_start = round_start_q;
    assign busy        = hold_active;
    assign game_won    = game_won_q;
    assign game_over   = game_over_q;

endmodule

// File: tb/tb_level_controller.sv
// Self-checking bench for level_controller: directed test-plan scenarios then random pulses.
// Outputs are compared one time unit after each rising edge against a behavioural game model.
// Inputs are driven right after the comparison so they are stable for the next edge.
module tb_level_controller;

    localparam int MAX_LEVEL   = 8;
    localparam int LIVES       = 3;
    localparam int HOLD_CYCLES = 4;

    logic       clk;
    logic       rst;
    logic       start;
    logic       round_pass;
    logic       round_fail;
    logic [3:0] curr_level;
    logic [1:0] lives_left;
    logic       round_start;
    logic       busy;
    logic       game_won;
    logic       game_over;

    int checks = 0;
    int errors = 0;

    // Game model: a game is "in play" between start and win/lose; a hold is a
    // number of busy cycles still to run, after which a new round is announced.
    int m_level     = 0;
    int m_lives     = 0;
    int m_hold_left = 0;
    bit m_in_play   = 0;
    bit m_advance   = 0;
    bit m_won       = 0;
    bit m_lost      = 0;
    bit m_rstart    = 0;

    level_controller #(
        .MAX_LEVEL   (MAX_LEVEL),
        .LIVES       (LIVES),
        .HOLD_CYCLES (HOLD_CYCLES)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .round_pass  (round_pass),
        .round_fail  (round_fail),
        .curr_level  (curr_level),
        .lives_left  (lives_left),
        .round_start (round_start),
        .busy        (busy),
        .game_won    (game_won),
        .game_over   (game_over)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    // Advance the model by one clock edge with the inputs sampled there.
    task automatic model_step(input bit s, input bit p, input bit f, input bit r);
        m_rstart = 0;
        if (r) begin
            m_level     = 0;
            m_lives     = 0;
            m_hold_left = 0;
            m_in_play   = 0;
            m_won       = 0;
            m_lost      = 0;
        end else if (m_hold_left > 0) begin
            m_hold_left--;
            if (m_hold_left == 0) begin
                if (m_advance) m_level++;
                m_rstart = 1;
            end
        end else if (!m_in_play) begin
            if (s) begin
                m_level   = 1;
                m_lives   = LIVES;
                m_won     = 0;
                m_lost    = 0;
                m_in_play = 1;
                m_rstart  = 1;
            end
        end else if (f) begin
            m_lives--;
            if (m_lives == 0) begin
                m_lost    = 1;
                m_in_play = 0;
            end else begin
                m_hold_left = HOLD_CYCLES;
                m_advance   = 0;
            end
        end else if (p) begin
            if (m_level == MAX_LEVEL) begin
                m_won     = 1;
                m_in_play = 0;
            end else begin
                m_hold_left = HOLD_CYCLES;
                m_advance   = 1;
            end
        end
    endtask

    // One clock: apply inputs, step the model, compare every output.
    task automatic tick(input bit s, input bit p, input bit f, input bit r);
        start      = s;
        round_pass = p;
        round_fail = f;
        rst        = r;
        @(posedge clk);
        model_step(s, p, f, r);
        #1;
        chk("curr_level",  32'(curr_level),  32'(m_level));
        chk("lives_left",  32'(lives_left),  32'(m_lives));
        chk("round_start", 32'(round_start), 32'(m_rstart));
        chk("busy",        32'(busy),        32'(m_hold_left > 0));
        chk("game_won",    32'(game_won),    32'(m_won));
        chk("game_over",   32'(game_over),   32'(m_lost));
        start      = 0;
        round_pass = 0;
        round_fail = 0;
        rst        = 0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick(0, 0, 0, 0);
    endtask

    initial begin
        rst        = 1;
        start      = 0;
        round_pass = 0;
        round_fail = 0;

        // Reset state.
        tick(0, 0, 0, 1);
        chk("rst_level", 32'(curr_level), 0);
        chk("rst_busy",  32'(busy), 0);

        // Start: level 1, full lives, one round_start pulse.
        tick(1, 0, 0, 0);
        chk("start_level", 32'(curr_level), 1);
        chk("start_lives", 32'(lives_left), 3);
        chk("start_rs",    32'(round_start), 1);
        idle(1);
        chk("rs_single", 32'(round_start), 0);

        // Pass at level 1: four busy cycles at level 1, then level 2 with round_start.
        tick(0, 1, 0, 0);
        idle(3);
        chk("hold_busy",  32'(busy), 1);
        chk("hold_level", 32'(curr_level), 1);
        idle(1);
        chk("post_hold_busy",  32'(busy), 0);
        chk("post_hold_level", 32'(curr_level), 2);
        chk("post_hold_rs",    32'(round_start), 1);

        // Three fails; the last ends the game without a new round.
        tick(0, 0, 1, 0);
        idle(5);
        tick(0, 0, 1, 0);
        chk("fail2_lives", 32'(lives_left), 1);
        idle(5);
        tick(0, 0, 1, 0);
        chk("fail3_over", 32'(game_over), 1);
        chk("fail3_rs",   32'(round_start), 0);
        idle(2);

        // Restart and pass through all levels to a win.
        tick(1, 0, 0, 0);
        for (int l = 1; l < MAX_LEVEL; l++) begin
            tick(0, 1, 0, 0);
            idle(5);
        end
        chk("top_level", 32'(curr_level), MAX_LEVEL);
        tick(0, 1, 0, 0);
        chk("win_flag",  32'(game_won), 1);
        chk("win_level", 32'(curr_level), MAX_LEVEL);
        idle(2);
        tick(1, 0, 0, 0);
        chk("restart_won", 32'(game_won), 0);
        chk("restart_rs",  32'(round_start), 1);

        // Reach level 3, then simultaneous pass+fail; passes during the hold are dropped.
        tick(0, 1, 0, 0);
        idle(5);
        tick(0, 1, 0, 0);
        idle(5);
        tick(0, 1, 1, 0);
        chk("both_lives", 32'(lives_left), 2);
        tick(0, 1, 0, 0);
        tick(0, 1, 0, 0);
        idle(3);
        chk("both_level", 32'(curr_level), 3);

        // Reset in the middle of a hold, then a pass that must be ignored.
        tick(0, 1, 0, 0);
        idle(1);
        tick(0, 0, 0, 1);
        chk("midhold_rst_busy", 32'(busy), 0);
        tick(0, 1, 0, 0);
        chk("idle_pass_level", 32'(curr_level), 0);
        idle(2);

        // Random pulses with occasional resets and restarts.
        for (int i = 0; i < 3000; i++) begin
            tick($urandom_range(0, 19) == 0,
                 $urandom_range(0, 3) == 0,
                 $urandom_range(0, 6) == 0,
                 $urandom_range(0, 299) == 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
